// File: rtl/placar_pontuacao_pkg.sv
// Shared types and constants for the basketball score-keeping back end.
package placar_pkg;

   localparam int SCORE_W       = 7;
   localparam int BCD_W         = 4;
   localparam int MAX_SCORE_DEF = 99;
   localparam int DEZ           = 10;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      APLICA   = 2'd1,
      CONVERTE = 2'd2,
      ALARME   = 2'd3
   } estado_t;

endpackage

// File: rtl/placar_pontuacao_conversor_bcd.sv
// Iterative binary-to-BCD converter: subtracts ten per cycle until the remainder is a single digit.
module conversor_bcd
   import placar_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SCORE_W-1:0] valor,
   output logic               done,
   output logic [BCD_W-1:0]   dez,
   output logic [BCD_W-1:0]   uni
);

   logic [SCORE_W-1:0] resto_q, resto_d;
   logic [BCD_W-1:0]   dez_q, dez_d;
   logic               ativo_q, ativo_d;
   logic               resto_menor;

   assign resto_menor = (resto_q < SCORE_W'(DEZ));

   always_comb begin
      resto_d = resto_q;
      dez_d   = dez_q;
      ativo_d = ativo_q;
      if (start) begin
         resto_d = valor;
         dez_d   = '0;
         ativo_d = 1'b1;
      end else if (ativo_q) begin
         if (!resto_menor) begin
            resto_d = resto_q - SCORE_W'(DEZ);
            dez_d   = dez_q + BCD_W'(1);
         end else begin
            ativo_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resto_q <= '0;
         dez_q   <= '0;
         ativo_q <= 1'b0;
      end else begin
         resto_q <= resto_d;
         dez_q   <= dez_d;
         ativo_q <= ativo_d;
      end
   end

   // done is combinational so the top can latch the digits in the same cycle the remainder settles.
   assign done = ativo_q && resto_menor;
   assign dez  = dez_q;
   assign uni  = resto_q[BCD_W-1:0];

endmodule

// File: rtl/placar_pontuacao.sv
// Scoreboard back end: validates point commands, keeps both team scores and their BCD digits,
// and sounds the buzzer on rejected commands.
module placar_pontuacao
   import placar_pkg::*;
#(
   parameter int BUZZ_CYCLES = 25_000_000,
   parameter int MAX_SCORE   = MAX_SCORE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pontos_valid,
   input  logic [1:0]         pontos,
   input  logic               subtrair,
   input  logic               time_sel,
   input  logic               zerar,
   output logic [SCORE_W-1:0] placar_t0,
   output logic [SCORE_W-1:0] placar_t1,
   output logic [BCD_W-1:0]   t0_dez,
   output logic [BCD_W-1:0]   t0_uni,
   output logic [BCD_W-1:0]   t1_dez,
   output logic [BCD_W-1:0]   t1_uni,
   output logic               ocupado,
   output logic               aceito,
   output logic               rejeitado,
   output logic               buzzer,
   output logic               led
);

   localparam int CNT_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(BUZZ_CYCLES - 1);

   estado_t            estado_q, estado_d;
   logic [1:0]         pontos_q, pontos_d;
   logic               sub_q, sub_d;
   logic               sel_q, sel_d;
   logic [SCORE_W-1:0] placar_t0_q, placar_t0_d, placar_t1_q, placar_t1_d;
   logic [BCD_W-1:0]   t0_dez_q, t0_dez_d, t0_uni_q, t0_uni_d;
   logic [BCD_W-1:0]   t1_dez_q, t1_dez_d, t1_uni_q, t1_uni_d;
   logic               ocupado_q, ocupado_d;
   logic               aceito_q, aceito_d;
   logic               rejeitado_q, rejeitado_d;
   logic               buzzer_q, buzzer_d;
   logic               led_q, led_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [SCORE_W-1:0] score_sel;
   logic [7:0]         novo;
   logic               invalido;
   logic               conv_start, conv_done;
   logic [BCD_W-1:0]   conv_dez, conv_uni;

   assign score_sel = sel_q ? placar_t1_q : placar_t0_q;
   assign novo      = sub_q ? ({1'b0, score_sel} - {6'd0, pontos_q})
                            : ({1'b0, score_sel} + {6'd0, pontos_q});
   // A negative difference sets bit 7, so it also exceeds any legal MAX_SCORE (<=127).
   assign invalido   = (pontos_q == 2'd0) || novo[7] || (novo > 8'(MAX_SCORE));
   assign conv_start = (estado_q == APLICA) && !invalido && !zerar;

   conversor_bcd u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .valor (novo[SCORE_W-1:0]),
      .done  (conv_done),
      .dez   (conv_dez),
      .uni   (conv_uni)
   );

   always_comb begin
      estado_d    = estado_q;
      pontos_d    = pontos_q;
      sub_d       = sub_q;
      sel_d       = sel_q;
      placar_t0_d = placar_t0_q;
      placar_t1_d = placar_t1_q;
      t0_dez_d    = t0_dez_q;
      t0_uni_d    = t0_uni_q;
      t1_dez_d    = t1_dez_q;
      t1_uni_d    = t1_uni_q;
      aceito_d    = 1'b0;
      rejeitado_d = 1'b0;
      buzzer_d    = buzzer_q;
      led_d       = led_q;
      cnt_d       = cnt_q;
      if (zerar) begin
         estado_d    = OCIOSO;
         placar_t0_d = '0;
         placar_t1_d = '0;
         t0_dez_d    = '0;
         t0_uni_d    = '0;
         t1_dez_d    = '0;
         t1_uni_d    = '0;
         buzzer_d    = 1'b0;
         led_d       = 1'b0;
         cnt_d       = '0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (pontos_valid) begin
                  pontos_d = pontos;
                  sub_d    = subtrair;
                  sel_d    = time_sel;
                  estado_d = APLICA;
               end
            end
            APLICA: begin
               if (invalido) begin
                  rejeitado_d = 1'b1;
                  buzzer_d    = 1'b1;
                  cnt_d       = CNT_INI;
                  estado_d    = ALARME;
               end else begin
                  if (sel_q) placar_t1_d = novo[SCORE_W-1:0];
                  else       placar_t0_d = novo[SCORE_W-1:0];
                  led_d    = sel_q;
                  aceito_d = 1'b1;
                  estado_d = CONVERTE;
               end
            end
            CONVERTE: begin
               if (conv_done) begin
                  if (sel_q) begin
                     t1_dez_d = conv_dez;
                     t1_uni_d = conv_uni;
                  end else begin
                     t0_dez_d = conv_dez;
                     t0_uni_d = conv_uni;
                  end
                  estado_d = OCIOSO;
               end
            end
            ALARME: begin
               if (cnt_q == '0) begin
                  buzzer_d = 1'b0;
                  estado_d = OCIOSO;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: estado_d = OCIOSO;
         endcase
      end
      ocupado_d = (estado_d != OCIOSO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= OCIOSO;
         pontos_q    <= '0;
         sub_q       <= 1'b0;
         sel_q       <= 1'b0;
         placar_t0_q <= '0;
         placar_t1_q <= '0;
         t0_dez_q    <= '0;
         t0_uni_q    <= '0;
         t1_dez_q    <= '0;
         t1_uni_q    <= '0;
         ocupado_q   <= 1'b0;
         aceito_q    <= 1'b0;
         rejeitado_q <= 1'b0;
         buzzer_q    <= 1'b0;
         led_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         estado_q    <= estado_d;
         pontos_q    <= pontos_d;
         sub_q       <= sub_d;
         sel_q       <= sel_d;
         placar_t0_q <= placar_t0_d;
         placar_t1_q <= placar_t1_d;
         t0_dez_q    <= t0_dez_d;
         t0_uni_q    <= t0_uni_d;
         t1_dez_q    <= t1_dez_d;
         t1_uni_q    <= t1_uni_d;
         ocupado_q   <= ocupado_d;
         aceito_q    <= aceito_d;
         rejeitado_q <= rejeitado_d;
         buzzer_q    <= buzzer_d;
         led_q       <= led_d;
         cnt_q       <= cnt_d;
      end
   end

   assign placar_t0 = placar_t0_q;
   assign placar_t1 = placar_t1_q;
   assign t0_dez    = t0_dez_q;
   assign t0_uni    = t0_uni_q;
   assign t1_dez    = t1_dez_q;
   assign t1_uni    = t1_uni_q;
   assign ocupado   = ocupado_q;
   assign aceito    = aceito_q;
   assign rejeitado = rejeitado_q;
   assign buzzer    = buzzer_q;
   assign led       = led_q;

endmodule

// File: tb/tb_placar_pontuacao.sv
// Randomized and directed bench for placar_pontuacao against an arithmetic score model.
module tb_placar_pontuacao;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pontos_valid = 1'b0;
   logic [1:0] pontos = 2'd0;
   logic       subtrair = 1'b0;
   logic       time_sel = 1'b0;
   logic       zerar = 1'b0;
   logic [6:0] placar_t0, placar_t1;
   logic [3:0] t0_dez, t0_uni, t1_dez, t1_uni;
   logic       ocupado, aceito, rejeitado, buzzer, led;

   int errors = 0;
   int checks = 0;
   int m_score[2];
   int m_dez[2];
   int m_uni[2];
   int m_led;

   placar_pontuacao #(.BUZZ_CYCLES(4), .MAX_SCORE(99)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pontos_valid (pontos_valid),
      .pontos       (pontos),
      .subtrair     (subtrair),
      .time_sel     (time_sel),
      .zerar        (zerar),
      .placar_t0    (placar_t0),
      .placar_t1    (placar_t1),
      .t0_dez       (t0_dez),
      .t0_uni       (t0_uni),
      .t1_dez       (t1_dez),
      .t1_uni       (t1_uni),
      .ocupado      (ocupado),
      .aceito       (aceito),
      .rejeitado    (rejeitado),
      .buzzer       (buzzer),
      .led          (led)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] obs_score(input int t);
      return (t != 0) ? placar_t1 : placar_t0;
   endfunction

   function automatic logic [3:0] obs_dez(input int t);
      return (t != 0) ? t1_dez : t0_dez;
   endfunction

   function automatic logic [3:0] obs_uni(input int t);
      return (t != 0) ? t1_uni : t0_uni;
   endfunction

   task automatic model_clear();
      for (int t = 0; t < 2; t++) begin
         m_score[t] = 0;
         m_dez[t]   = 0;
         m_uni[t]   = 0;
      end
      m_led = 0;
   endtask

   task automatic chk_zero(input string tag);
      verifica({tag, "_t0"}, placar_t0, 0);
      verifica({tag, "_t1"}, placar_t1, 0);
      verifica({tag, "_bcd"}, {t0_dez, t0_uni, t1_dez, t1_uni}, 0);
      verifica({tag, "_ocupado"}, ocupado, 0);
      verifica({tag, "_pulsos"}, {aceito, rejeitado}, 0);
      verifica({tag, "_buzzer"}, buzzer, 0);
      verifica({tag, "_led"}, led, 0);
   endtask

   // One full command; optionally fires an extra strobe in the middle of conversion.
   task automatic cmd(input int p, input int sub, input int team, input int inject);
      int n, ok, cnt;
      n  = (sub != 0) ? m_score[team] - p : m_score[team] + p;
      ok = (p != 0 && n >= 0 && n <= 99) ? 1 : 0;
      pontos = 2'(p); subtrair = (sub != 0); time_sel = (team != 0); pontos_valid = 1'b1;
      tick();
      pontos_valid = 1'b0;
      pontos = 2'($urandom); subtrair = 1'($urandom); time_sel = 1'($urandom);
      verifica("ocupado_k", ocupado, 1);
      verifica("pulso_k", {aceito, rejeitado}, 0);
      tick();
      if (ok != 0) begin
         m_score[team] = n;
         m_led = team;
      end
      $display("cmd team=%0d %s %0d -> %s score=%0d", team, (sub != 0) ? "sub" : "add", p,
               (ok != 0) ? "accept" : "reject", m_score[team]);
      verifica("aceito", aceito, ok);
      verifica("rejeitado", rejeitado, (ok == 0));
      verifica("placar", obs_score(team), m_score[team]);
      verifica("placar_outro", obs_score(1 - team), m_score[1 - team]);
      verifica("led", led, m_led);
      if (ok != 0) begin
         for (int j = 1; j <= n / 10; j++) begin
            if (inject != 0 && j == 2) begin
               pontos = 2'd1; subtrair = 1'b0; time_sel = (team != 0); pontos_valid = 1'b1;
            end
            tick();
            pontos_valid = 1'b0;
            verifica("ocupado_conv", ocupado, 1);
            verifica("aceito_conv", aceito, 0);
            verifica("bcd_antigo", {obs_dez(team), obs_uni(team)}, {4'(m_dez[team]), 4'(m_uni[team])});
         end
         tick();
         m_dez[team] = n / 10;
         m_uni[team] = n % 10;
         verifica("bcd_dez", obs_dez(team), m_dez[team]);
         verifica("bcd_uni", obs_uni(team), m_uni[team]);
         verifica("ocupado_fim", ocupado, 0);
      end else begin
         verifica("buzzer_on", buzzer, 1);
         cnt = 1;
         while (cnt < 20) begin
            tick();
            if (buzzer !== 1'b1) break;
            cnt++;
            verifica("ocupado_alarme", ocupado, 1);
         end
         verifica("buzzer_ciclos", cnt, 4);
         verifica("ocupado_fim", ocupado, 0);
         verifica("placar_rej", obs_score(team), m_score[team]);
      end
   endtask

   task automatic set_score(input int team, input int alvo);
      int d;
      while (m_score[team] != alvo) begin
         d = alvo - m_score[team];
         if (d > 0) cmd((d > 3) ? 3 : d, 0, team, 0);
         else       cmd((-d > 3) ? 3 : -d, 1, team, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      cmd(2, 0, 0, 0);
      set_score(1, 97);
      cmd(3, 0, 1, 0);
      set_score(0, 1);
      cmd(2, 1, 0, 0);
      cmd(1, 1, 0, 0);
      set_score(1, 96);
      cmd(3, 0, 1, 1);
      repeat (3) tick();
      verifica("placar_t1_99", placar_t1, 99);
      verifica("ocupado_pos_inject", ocupado, 0);
      cmd(0, 0, 1, 0);

      // zerar while the buzzer is sounding
      pontos = 2'd0; pontos_valid = 1'b1;
      tick();
      pontos_valid = 1'b0;
      tick();
      verifica("rej_pre_zerar", rejeitado, 1);
      tick();
      verifica("buzzer_pre_zerar", buzzer, 1);
      zerar = 1'b1;
      tick();
      zerar = 1'b0;
      model_clear();
      chk_zero("zerar_alarme");

      // zerar wins over a simultaneous strobe
      cmd(3, 0, 0, 0);
      cmd(2, 0, 1, 0);
      pontos = 2'd1; subtrair = 1'b0; time_sel = 1'b0; pontos_valid = 1'b1; zerar = 1'b1;
      tick();
      pontos_valid = 1'b0; zerar = 1'b0;
      model_clear();
      chk_zero("zerar_strobe");
      tick();
      chk_zero("zerar_strobe_pos");

      repeat (60) begin
         repeat ($urandom_range(0, 2)) tick();
         cmd($urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 1), 0);
      end

      // asynchronous reset in the middle of a conversion
      set_score(0, 40);
      pontos = 2'd3; subtrair = 1'b0; time_sel = 1'b0; pontos_valid = 1'b1;
      tick();
      pontos_valid = 1'b0;
      tick();
      verifica("aceito_pre_reset", aceito, 1);
      #3 rst_n = 1'b0;
      #1;
      model_clear();
      chk_zero("reset_async");
      tick();
      rst_n = 1'b1;
      tick();
      chk_zero("reset_pos");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
